fpu_cmd_seq: RTL

Command sequencer driving the FPU load/execute protocol from the initiator side. Accepts a whole operation (operand A, operand B, opcode) in one handshake and serialises it onto the FPU's shared `data`/`start` bus as four start-strobed words. It then waits for the FPU's `ready` or `error` and returns a one-cycle completion response. It sits between any requesting master (CPU bridge, test sequencer) and the FPU, so masters never hand-time start pulses.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fpu_cmd_seq_if.sv | 31 +++
 rtl/fpu_cmd_wdog.sv | 29 ++
 rtl/fpu_cmd_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode encoding, the execute word that closes a
// load sequence, and the command sequencer state encoding.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } fpu_op_e;

    // Opcode value 3 has no FPU meaning and is rejected without bus traffic.
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    // Fourth word of every sequence; its strobe triggers execution.
    localparam logic [15:0] EXEC_WORD = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

endpackage

// File: rtl/fpu_cmd_seq_if.sv
// Bundle between a requesting master, the command sequencer and the FPU.
//   req_*   : whole-operation request handshake (valid/ready) with operands
//   fpu_*   : shared FPU load/execute bus plus its ready/error levels
//   rsp_*   : one-cycle completion pulse with error/timeout qualifiers
// master = environment side (requester + FPU), slave = sequencer side.
interface fpu_cmd_seq_if #(
    parameter int W = 16
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [1:0]   req_op;
    logic [W-1:0] fpu_data;
    logic         fpu_start;
    logic         fpu_ready;
    logic         fpu_error;
    logic         rsp_valid;
    logic         rsp_error;
    logic         rsp_timeout;

    modport master (
        output req_valid, req_a, req_b, req_op, fpu_ready, fpu_error,
        input  req_ready, fpu_data, fpu_start, rsp_valid, rsp_error, rsp_timeout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, fpu_ready, fpu_error,
        output req_ready, fpu_data, fpu_start, rsp_valid, rsp_error, rsp_timeout
    );
endinterface

// File: rtl/fpu_cmd_wdog.sv
// WAIT-phase watchdog for the FPU command sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear the count (sequencer not waiting)
//   inc      : count one waiting cycle
//   expire   : high in the TIMEOUT-th consecutive counted cycle
module fpu_cmd_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of already-completed waiting cycles, so the
    // TIMEOUT-th cycle is the one that sees TIMEOUT-1. Saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != CW'(TIMEOUT))
            cnt <= cnt + 1'b1;
    end

    assign expire = inc && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fpu_cmd_seq.sv
// FPU command sequencer. Accepts one operation per handshake and serialises
// it onto the FPU bus as four start-strobed words (A, B, op, EXEC_WORD) with
// GAP idle cycles after each strobe, then waits for fpu_ready/fpu_error and
// emits a one-cycle rsp_valid.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fpu_cmd_seq_if slave (request, FPU bus, response)
// Parameters: W data width, GAP idle cycles per strobe, TIMEOUT wait bound.
// Optional: define FPU_CMD_SEQ_TIMEOUT_EN to bound WAIT with fpu_cmd_wdog;
// otherwise WAIT is unbounded and rsp_timeout stays 0.
module fpu_cmd_seq
    import fpu_pkg::*;
#(
    parameter int W       = 16,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    fpu_cmd_seq_if.slave bus
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    seq_state_e    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          err_q, err_d, tmo_q, tmo_d;
    logic [W-1:0]  a_q, b_q;
    logic [1:0]    op_q;
    logic          accept, wd_expire;
    logic [W-1:0]  word;
    logic          rdy_d, start_d, rv_d, re_d, rt_d;
    logic [W-1:0]  data_d;

    assign accept = bus.req_valid && bus.req_ready;

`ifdef FPU_CMD_SEQ_TIMEOUT_EN
    fpu_cmd_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != ST_WAIT),
        .inc    (state_q == ST_WAIT),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    // State, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            gcnt_q          <= '0;
            err_q           <= 1'b0;
            tmo_q           <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            op_q            <= '0;
            bus.req_ready   <= 1'b1;
            bus.fpu_start   <= 1'b0;
            bus.fpu_data    <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_error   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            gcnt_q          <= gcnt_d;
            err_q           <= err_d;
            tmo_q           <= tmo_d;
            if (accept) begin
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
                op_q <= bus.req_op;
            end
            bus.req_ready   <= rdy_d;
            bus.fpu_start   <= start_d;
            bus.fpu_data    <= data_d;
            bus.rsp_valid   <= rv_d;
            bus.rsp_error   <= re_d;
            bus.rsp_timeout <= rt_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d = '0;
                    err_d = 1'b0;
                    tmo_d = 1'b0;
                    if (bus.req_op == OP_ILLEGAL) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (idx_q == 2'd3) begin
                    state_d = ST_WAIT;
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                    gcnt_d  = '0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GW'(GAP - 1)) begin
                    state_d = ST_SEND;
                    idx_d   = idx_q + 2'd1;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // Error beats ready; a real FPU answer beats the watchdog.
                if (bus.fpu_error) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else if (bus.fpu_ready) begin
                    state_d = ST_RESP;
                end else if (wd_expire) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding latency. Word 0 is only ever sent straight out of the
    // accept cycle, so it comes from the live request rather than a_q.
    always_comb begin
        word = '0;
        unique case (idx_d)
            2'd0: word = accept ? bus.req_a : a_q;
            2'd1: word = b_q;
            2'd2: word = {{(W-2){1'b0}}, op_q};
            2'd3: word = W'(EXEC_WORD);
            default: word = '0;
        endcase
        rdy_d   = (state_d == ST_IDLE);
        start_d = (state_d == ST_SEND);
        data_d  = start_d ? word : '0;
        rv_d    = (state_d == ST_RESP);
        re_d    = rv_d && err_d;
        rt_d    = rv_d && tmo_d;
    end
endmodule
